// File: rtl/edge_rasterizer_stream.sv
// Streaming edge-function rasterizer: latches one triangle, clips its bounding box to the
// screen, then walks the box with incremental signed edge functions emitting covered pixels.
module edge_rasterizer_stream #(
   parameter int COORD_W  = 16,
   parameter int COLOR_W  = 16,
   parameter int DEPTH_W  = 2,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] in_v0_x,
   input  logic [COORD_W-1:0] in_v1_x,
   input  logic [COORD_W-1:0] in_v2_x,
   input  logic [COORD_W-1:0] in_v0_y,
   input  logic [COORD_W-1:0] in_v1_y,
   input  logic [COORD_W-1:0] in_v2_y,
   input  logic [DEPTH_W-1:0] in_v0_depth,
   input  logic [DEPTH_W-1:0] in_v1_depth,
   input  logic [DEPTH_W-1:0] in_v2_depth,
   input  logic [COLOR_W-1:0] in_color,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic [DEPTH_W-1:0] out_depth,
   output logic [COLOR_W-1:0] out_color,
   output logic               out_done
);
   localparam int EW = 2*COORD_W + 3;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);
   localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

   typedef logic signed [EW-1:0] edge_t;
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BBOX  = 3'd1,
      ST_SETUP = 3'd2,
      ST_SCAN  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic edge_t ext(input logic [COORD_W-1:0] v);
      ext = $signed({{(EW-COORD_W){1'b0}}, v});
   endfunction

   function automatic edge_t eval_edge(input edge_t a, input edge_t b, input edge_t c,
                                       input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      eval_edge = a*ext(x) + b*ext(y) + c;
   endfunction

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      min3 = (c < m) ? c : m;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      max3 = (c > m) ? c : m;
   endfunction

   function automatic logic [DEPTH_W-1:0] dmin3(input logic [DEPTH_W-1:0] a,
                                                input logic [DEPTH_W-1:0] b,
                                                input logic [DEPTH_W-1:0] c);
      logic [DEPTH_W-1:0] m;
      m = (a < b) ? a : b;
      dmin3 = (c < m) ? c : m;
   endfunction

   state_t state_r, state_s;

   logic [COORD_W-1:0] v0x_r, v1x_r, v2x_r, v0y_r, v1y_r, v2y_r;
   logic [DEPTH_W-1:0] d0_r, d1_r, d2_r, depth_r;
   logic [COLOR_W-1:0] color_r;
   logic [COORD_W-1:0] min_x_r, max_x_r, min_y_r, max_y_r, x_r, y_r;
   edge_t a_r [3];
   edge_t b_r [3];
   edge_t row_r [3];
   edge_t cur_r [3];
   logic last_r;

   logic               in_ready_r, out_valid_r, out_done_r;
   logic [COORD_W-1:0] out_x_r, out_y_r;
   logic [DEPTH_W-1:0] out_depth_r;
   logic [COLOR_W-1:0] out_color_r;

   logic [COORD_W-1:0] bmin_x_s, bmax_x_s, bmin_y_s, bmax_y_s;
   logic               off_screen_s, stall_s, covered_s, row_end_s, at_last_s, neg_s;
   edge_t a_s [3];
   edge_t b_s [3];
   edge_t c_s [3];
   edge_t an_s [3];
   edge_t bn_s [3];
   edge_t start_s [3];
   edge_t area_s;

   // Bounding box, scan status and winding-normalised edge coefficients.
   always_comb begin
      bmin_x_s     = min3(v0x_r, v1x_r, v2x_r);
      bmax_x_s     = max3(v0x_r, v1x_r, v2x_r);
      bmin_y_s     = min3(v0y_r, v1y_r, v2y_r);
      bmax_y_s     = max3(v0y_r, v1y_r, v2y_r);
      off_screen_s = (bmin_x_s > X_LAST) || (bmin_y_s > Y_LAST);
      stall_s      = out_valid_r && !out_ready;
      covered_s    = !cur_r[0][EW-1] && !cur_r[1][EW-1] && !cur_r[2][EW-1];
      row_end_s    = (x_r == max_x_r);
      at_last_s    = row_end_s && (y_r == max_y_r);

      a_s[0] = ext(v1y_r) - ext(v2y_r);
      b_s[0] = ext(v2x_r) - ext(v1x_r);
      c_s[0] = ext(v1x_r)*ext(v2y_r) - ext(v2x_r)*ext(v1y_r);
      a_s[1] = ext(v2y_r) - ext(v0y_r);
      b_s[1] = ext(v0x_r) - ext(v2x_r);
      c_s[1] = ext(v2x_r)*ext(v0y_r) - ext(v0x_r)*ext(v2y_r);
      a_s[2] = ext(v0y_r) - ext(v1y_r);
      b_s[2] = ext(v1x_r) - ext(v0x_r);
      c_s[2] = ext(v0x_r)*ext(v1y_r) - ext(v1x_r)*ext(v0y_r);
      area_s = eval_edge(a_s[0], b_s[0], c_s[0], v0x_r, v0y_r);
      // Clockwise triangles are flipped so that "inside" is always E >= 0.
      neg_s  = area_s[EW-1];
      for (int i = 0; i < 3; i++) begin
         an_s[i]    = neg_s ? -a_s[i] : a_s[i];
         bn_s[i]    = neg_s ? -b_s[i] : b_s[i];
         start_s[i] = neg_s ? -eval_edge(a_s[i], b_s[i], c_s[i], min_x_r, min_y_r)
                            :  eval_edge(a_s[i], b_s[i], c_s[i], min_x_r, min_y_r);
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid && in_ready_r) state_s = ST_BBOX;
            else                        state_s = ST_IDLE;
         end
         ST_BBOX: begin
            if (off_screen_s) state_s = ST_DONE;
            else              state_s = ST_SETUP;
         end
         ST_SETUP: begin
            if (area_s == '0) state_s = ST_DONE;
            else              state_s = ST_SCAN;
         end
         ST_SCAN: begin
            if (stall_s)                       state_s = ST_SCAN;
            else if (last_r)                   state_s = ST_DONE;
            else if (at_last_s && !covered_s)  state_s = ST_DONE;
            else                               state_s = ST_SCAN;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_s;
   end

   // Triangle latch, setup, scan iterator and registered pixel outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         {v0x_r, v1x_r, v2x_r, v0y_r, v1y_r, v2y_r} <= '0;
         {d0_r, d1_r, d2_r, depth_r} <= '0;
         color_r     <= '0;
         {min_x_r, max_x_r, min_y_r, max_y_r, x_r, y_r} <= '0;
         a_r         <= '{default: '0};
         b_r         <= '{default: '0};
         row_r       <= '{default: '0};
         cur_r       <= '{default: '0};
         last_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_done_r  <= 1'b0;
         out_x_r     <= '0;
         out_y_r     <= '0;
         out_depth_r <= '0;
         out_color_r <= '0;
      end else begin
         in_ready_r <= (state_s == ST_IDLE);
         out_done_r <= (state_s == ST_DONE);
         case (state_r)
            ST_IDLE: begin
               if (in_valid && in_ready_r) begin
                  v0x_r <= in_v0_x;  v1x_r <= in_v1_x;  v2x_r <= in_v2_x;
                  v0y_r <= in_v0_y;  v1y_r <= in_v1_y;  v2y_r <= in_v2_y;
                  d0_r  <= in_v0_depth;  d1_r <= in_v1_depth;  d2_r <= in_v2_depth;
                  color_r <= in_color;
               end
            end
            ST_BBOX: begin
               min_x_r <= bmin_x_s;
               min_y_r <= bmin_y_s;
               max_x_r <= (bmax_x_s > X_LAST) ? X_LAST : bmax_x_s;
               max_y_r <= (bmax_y_s > Y_LAST) ? Y_LAST : bmax_y_s;
               depth_r <= dmin3(d0_r, d1_r, d2_r);
            end
            ST_SETUP: begin
               a_r    <= an_s;
               b_r    <= bn_s;
               row_r  <= start_s;
               cur_r  <= start_s;
               x_r    <= min_x_r;
               y_r    <= min_y_r;
               last_r <= 1'b0;
            end
            ST_SCAN: begin
               if (!stall_s) begin
                  if (last_r) begin
                     out_valid_r <= 1'b0;
                  end else begin
                     out_valid_r <= covered_s;
                     if (covered_s) begin
                        out_x_r     <= x_r;
                        out_y_r     <= y_r;
                        out_depth_r <= depth_r;
                        out_color_r <= color_r;
                     end
                     // A covered final candidate keeps us in SCAN until it is taken.
                     if (at_last_s) begin
                        last_r <= covered_s;
                     end else if (row_end_s) begin
                        x_r <= min_x_r;
                        y_r <= y_r + ONE;
                        for (int i = 0; i < 3; i++) begin
                           row_r[i] <= row_r[i] + b_r[i];
                           cur_r[i] <= row_r[i] + b_r[i];
                        end
                     end else begin
                        x_r <= x_r + ONE;
                        for (int i = 0; i < 3; i++) cur_r[i] <= cur_r[i] + a_r[i];
                     end
                  end
               end
            end
            ST_DONE: out_valid_r <= 1'b0;
            default: out_valid_r <= 1'b0;
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_done  = out_done_r;
   assign out_x     = out_x_r;
   assign out_y     = out_y_r;
   assign out_depth = out_depth_r;
   assign out_color = out_color_r;

endmodule

// File: tb/tb_edge_rasterizer_stream.sv
// Bench for edge_rasterizer_stream: vector table plus random triangles, all checked against a
// cross-product coverage model; a second instance uses a 4-pixel-wide screen for clipping.
module tb_edge_rasterizer_stream;
   localparam int CW = 16;
   localparam int KW = 16;
   localparam int DW = 2;

   typedef struct {
      logic [CW-1:0] x0, y0, x1, y1, x2, y2;
      logic [DW-1:0] d0, d1, d2;
      logic [KW-1:0] color;
      int            mode;       // 0: ready always, 1: ready 1010..., 2: random
      bit            sel;        // 1 selects the SCREEN_W=4 instance
      int            exp_count;  // -1: no fixed count
      int            exp_first;  // -1: no fixed first-valid cycle
      int            exp_done;   // -1: no fixed done cycle
   } vec_t;

   typedef struct { int x; int y; } pix_t;

   logic clock = 1'b0;
   logic reset, in_valid, out_ready, sel;
   logic [CW-1:0] v0x, v0y, v1x, v1y, v2x, v2y;
   logic [DW-1:0] d0, d1, d2;
   logic [KW-1:0] color;

   logic a_in_valid, a_in_ready, a_out_valid, a_out_done;
   logic b_in_valid, b_in_ready, b_out_valid, b_out_done;
   logic [CW-1:0] a_out_x, a_out_y, b_out_x, b_out_y;
   logic [DW-1:0] a_out_depth, b_out_depth;
   logic [KW-1:0] a_out_color, b_out_color;

   logic o_in_ready, o_out_valid, o_out_done;
   logic [CW-1:0] o_x, o_y;
   logic [DW-1:0] o_depth;
   logic [KW-1:0] o_color;

   int checks = 0;
   int errors = 0;
   pix_t exp_q[$];

   assign a_in_valid  = in_valid & ~sel;
   assign b_in_valid  = in_valid & sel;
   assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
   assign o_out_valid = sel ? b_out_valid : a_out_valid;
   assign o_out_done  = sel ? b_out_done  : a_out_done;
   assign o_x         = sel ? b_out_x     : a_out_x;
   assign o_y         = sel ? b_out_y     : a_out_y;
   assign o_depth     = sel ? b_out_depth : a_out_depth;
   assign o_color     = sel ? b_out_color : a_out_color;

   always #5 clock = ~clock;

   edge_rasterizer_stream dut_a (
      .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_v0_x(v0x), .in_v1_x(v1x), .in_v2_x(v2x), .in_v0_y(v0y), .in_v1_y(v1y), .in_v2_y(v2y),
      .in_v0_depth(d0), .in_v1_depth(d1), .in_v2_depth(d2), .in_color(color),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_x(a_out_x), .out_y(a_out_y),
      .out_depth(a_out_depth), .out_color(a_out_color), .out_done(a_out_done));

   edge_rasterizer_stream #(.SCREEN_W(4)) dut_b (
      .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_v0_x(v0x), .in_v1_x(v1x), .in_v2_x(v2x), .in_v0_y(v0y), .in_v1_y(v1y), .in_v2_y(v2y),
      .in_v0_depth(d0), .in_v1_depth(d1), .in_v2_depth(d2), .in_color(color),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_x(b_out_x), .out_y(b_out_y),
      .out_depth(b_out_depth), .out_color(b_out_color), .out_done(b_out_done));

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input int x0, y0, x1, y1, x2, y2, input int mode, input bit s,
                               input int cnt, input int first, input int done);
      vec_t t;
      t.x0 = CW'(x0); t.y0 = CW'(y0); t.x1 = CW'(x1); t.y1 = CW'(y1);
      t.x2 = CW'(x2); t.y2 = CW'(y2);
      t.d0 = 2'd3; t.d1 = 2'd1; t.d2 = 2'd2; t.color = 16'hBEEF;
      t.mode = mode; t.sel = s; t.exp_count = cnt; t.exp_first = first; t.exp_done = done;
      return t;
   endfunction

   // Pixel centres on integer coordinates; inside means all three cross products share the
   // triangle's winding sign or are zero.
   task automatic build_expected(input vec_t t, input int sw, input int sh);
      longint x0, y0, x1, y1, x2, y2, area, w0, w1, w2;
      longint xlo, xhi, ylo, yhi;
      pix_t p;
      exp_q.delete();
      x0 = t.x0; y0 = t.y0; x1 = t.x1; y1 = t.y1; x2 = t.x2; y2 = t.y2;
      xlo = x0; if (x1 < xlo) xlo = x1; if (x2 < xlo) xlo = x2;
      xhi = x0; if (x1 > xhi) xhi = x1; if (x2 > xhi) xhi = x2;
      ylo = y0; if (y1 < ylo) ylo = y1; if (y2 < ylo) ylo = y2;
      yhi = y0; if (y1 > yhi) yhi = y1; if (y2 > yhi) yhi = y2;
      if (xhi > sw - 1) xhi = sw - 1;
      if (yhi > sh - 1) yhi = sh - 1;
      area = (x1 - x0)*(y2 - y0) - (x2 - x0)*(y1 - y0);
      if (xlo > sw - 1 || ylo > sh - 1 || area == 0) return;
      for (longint y = ylo; y <= yhi; y++) begin
         for (longint x = xlo; x <= xhi; x++) begin
            w0 = (x2 - x1)*(y - y1) - (y2 - y1)*(x - x1);
            w1 = (x0 - x2)*(y - y2) - (y0 - y2)*(x - x2);
            w2 = (x1 - x0)*(y - y0) - (y1 - y0)*(x - x0);
            if ((area > 0 && w0 >= 0 && w1 >= 0 && w2 >= 0) ||
                (area < 0 && w0 <= 0 && w1 <= 0 && w2 <= 0)) begin
               p.x = int'(x); p.y = int'(y);
               exp_q.push_back(p);
            end
         end
      end
   endtask

   // n counts falling edges after the accept edge (n=0 right after it).
   task automatic run_tri(input vec_t t, output int npix, output int first_n, output int done_n);
      int k;
      bit held;
      logic [CW-1:0] hx, hy;
      logic [DW-1:0] hd, dmin;
      logic [KW-1:0] hc;
      pix_t p;
      build_expected(t, t.sel ? 4 : 640, 480);
      dmin = t.d0;
      if (t.d1 < dmin) dmin = t.d1;
      if (t.d2 < dmin) dmin = t.d2;
      npix = 0; first_n = -1; done_n = -1; held = 1'b0;
      hx = '0; hy = '0; hd = '0; hc = '0;
      @(negedge clock);
      sel = t.sel; out_ready = 1'b1;
      v0x = t.x0; v0y = t.y0; v1x = t.x1; v1y = t.y1; v2x = t.x2; v2y = t.y2;
      d0 = t.d0; d1 = t.d1; d2 = t.d2; color = t.color; in_valid = 1'b1;
      k = 0;
      while (!o_in_ready && k < 50) begin
         @(negedge clock);
         k++;
      end
      if (!o_in_ready) begin
         chk("accept_timeout", o_in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clock);
      in_valid = 1'b0;
      chk("busy_in_ready", o_in_ready, 0);
      for (int n = 0; n < 4000; n++) begin
         if (n > 0) @(negedge clock);
         case (t.mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (n % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (held) begin
            chk("hold_valid", o_out_valid, 1);
            chk("hold_x", o_x, hx);
            chk("hold_y", o_y, hy);
         end
         if (o_out_valid) begin
            if (first_n < 0) first_n = n;
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL extra_pixel got=(%0d,%0d) expected=none", o_x, o_y);
               end else begin
                  p = exp_q.pop_front();
                  chk("pix_x", o_x, p.x);
                  chk("pix_y", o_y, p.y);
                  chk("pix_depth", o_depth, dmin);
                  chk("pix_color", o_color, t.color);
               end
               npix++;
            end
            held = !out_ready;
            hx = o_x; hy = o_y; hd = o_depth; hc = o_color;
         end else begin
            held = 1'b0;
         end
         if (o_out_done) begin
            done_n = n;
            chk("done_valid_low", o_out_valid, 0);
            break;
         end
      end
      if (done_n < 0) chk("done_timeout", o_out_done, 1);
      chk("missing_pixels", exp_q.size(), 0);
      @(negedge clock);
      chk("done_one_cycle", o_out_done, 0);
      chk("idle_in_ready", o_in_ready, 1);
      out_ready = 1'b1;
   endtask

   initial begin
      vec_t tbl[$];
      vec_t t;
      int npix, first_n, done_n, bx, by;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
      v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
      d0 = '0; d1 = '0; d2 = '0; color = '0;
      repeat (3) @(negedge clock);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_done", a_out_done, 0);
      chk("rst_out_x", a_out_x, 0);
      chk("rst_out_y", a_out_y, 0);
      chk("rst_out_depth", a_out_depth, 0);
      chk("rst_out_color", a_out_color, 0);
      reset = 1'b0;

      tbl.push_back(mk(0, 0, 4, 0, 0, 4, 0, 1'b0, 15, 3, -1));         // CCW, always ready
      tbl.push_back(mk(0, 0, 0, 4, 4, 0, 0, 1'b0, 15, 3, -1));         // same, CW winding
      tbl.push_back(mk(0, 0, 2, 2, 4, 4, 0, 1'b0, 0, -1, 2));          // collinear
      tbl.push_back(mk(0, 0, 4, 0, 0, 4, 1, 1'b0, 15, 3, -1));         // ready toggling
      tbl.push_back(mk(0, 0, 8, 0, 0, 8, 0, 1'b1, 30, 3, -1));         // 4-wide screen clip
      tbl.push_back(mk(700, 10, 710, 10, 700, 20, 0, 1'b0, 0, -1, 1)); // fully off-screen
      tbl.push_back(mk(639, 479, 700, 479, 639, 500, 1, 1'b0, 1, 3, -1)); // clipped to 1 pixel
      tbl.push_back(mk(5, 5, 5, 5, 5, 5, 0, 1'b0, 0, -1, 2));          // point triangle
      tbl.push_back(mk(3, 1, 12, 7, 1, 9, 2, 1'b0, -1, -1, -1));

      foreach (tbl[i]) begin
         run_tri(tbl[i], npix, first_n, done_n);
         if (tbl[i].exp_count >= 0) chk($sformatf("vec%0d_count", i), npix, tbl[i].exp_count);
         if (tbl[i].exp_first >= 0) chk($sformatf("vec%0d_first", i), first_n, tbl[i].exp_first);
         if (tbl[i].exp_done >= 0) chk($sformatf("vec%0d_done", i), done_n, tbl[i].exp_done);
      end

      // Reset in the middle of a scan abandons the triangle without a done pulse.
      @(negedge clock);
      sel = 1'b0; out_ready = 1'b1;
      v0x = 16'd0; v0y = 16'd0; v1x = 16'd8; v1y = 16'd0; v2x = 16'd0; v2y = 16'd8;
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (8) @(negedge clock);
      chk("pre_reset_valid", a_out_valid, 1);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_out_valid", a_out_valid, 0);
      chk("midrst_in_ready", a_in_ready, 1);
      chk("midrst_out_done", a_out_done, 0);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clock);
         chk("postrst_no_done", a_out_done, 0);
         chk("postrst_no_valid", a_out_valid, 0);
      end
      run_tri(mk(0, 0, 4, 0, 0, 4, 0, 1'b0, 15, 3, -1), npix, first_n, done_n);
      chk("postrst_count", npix, 15);

      for (int r = 0; r < 30; r++) begin
         bx = ($urandom_range(0, 3) == 0) ? 625 : int'($urandom_range(0, 40));
         by = ($urandom_range(0, 3) == 0) ? 465 : int'($urandom_range(0, 40));
         t = mk(bx + int'($urandom_range(0, 18)), by + int'($urandom_range(0, 18)),
                bx + int'($urandom_range(0, 18)), by + int'($urandom_range(0, 18)),
                bx + int'($urandom_range(0, 18)), by + int'($urandom_range(0, 18)),
                int'($urandom_range(0, 2)), 1'b0, -1, -1, -1);
         t.d0 = DW'($urandom_range(0, 3));
         t.d1 = DW'($urandom_range(0, 3));
         t.d2 = DW'($urandom_range(0, 3));
         t.color = KW'($urandom_range(0, 65535));
         run_tri(t, npix, first_n, done_n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
